piso_shift_reg: RTL

Parallel-in, serial-out shift register: the transmit-side counterpart of the serial-in left-shift register `shift_reg`. It accepts an MSB-wide word through a valid/ready load handshake and drives it out one bit per enabled clock, MSB first. A `shift_reg` instance with a matching `MSB` that samples `q` on the same enabled edges holds the original word in `out` after `MSB` shifts. The block sits on the serial link between a parallel data source and `shift_reg`.

---
 rtl/piso_shift_reg_if.sv | 23 ++
 rtl/piso_shift_reg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/piso_shift_reg_if.sv
// rtl/piso_shift_reg_if.sv - load handshake and serial output bundle for piso_shift_reg
interface piso_shift_reg_if #(
    parameter int MSB = 16
);
    logic           en;
    logic           load_valid;
    logic [MSB-1:0] load_data;
    logic           load_ready;
    logic           q;
    logic           q_valid;
    logic           busy;
    logic           done;

    modport master (
        output en, load_valid, load_data,
        input  load_ready, q, q_valid, busy, done
    );

    modport slave (
        input  en, load_valid, load_data,
        output load_ready, q, q_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shifter, MSB first; PISO_PARITY_EN appends an even-parity bit
module piso_shift_reg #(
    parameter int MSB = 16
) (
    input  logic              clk,
    input  logic              rst,
    piso_shift_reg_if.slave   s
);
    localparam int CW = $clog2(MSB + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [MSB-1:0] sr, sr_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           q_r, q_n;
    logic           qv_r, qv_n;
    logic           done_r, done_n;
    logic           ready;
    logic           accept;
`ifdef PISO_PARITY_EN
    logic           par, par_n;
`endif

    // Ready only looks at state, counter and en so it never depends on load_valid.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:   ready = 1'b1;
            SHIFT: begin
`ifdef PISO_PARITY_EN
                ready = 1'b0;
`else
                ready = s.en && (cnt == CW'(1));
`endif
            end
            PARITY: ready = s.en;
            default: ready = 1'b0;
        endcase
    end

    assign accept = s.load_valid && ready;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        q_n     = q_r;
        qv_n    = qv_r;
        done_n  = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par;
`endif
        case (state)
            SHIFT: begin
                if (s.en) begin
                    if (cnt > CW'(1)) begin
                        q_n   = sr[MSB-1];
                        sr_n  = {sr[MSB-2:0], 1'b0};
                        cnt_n = cnt - CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        state_n = PARITY;
                        q_n     = par;
                        cnt_n   = '0;
`else
                        state_n = IDLE;
                        q_n     = 1'b0;
                        qv_n    = 1'b0;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
            PARITY: begin
                if (s.en) begin
                    state_n = IDLE;
                    q_n     = 1'b0;
                    qv_n    = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: ;
        endcase

        // An accepted load overrides the end-of-frame path so back-to-back frames have no gap.
        if (accept) begin
            sr_n    = {s.load_data[MSB-2:0], 1'b0};
            q_n     = s.load_data[MSB-1];
            cnt_n   = CW'(MSB);
            qv_n    = 1'b1;
            done_n  = 1'b0;
            state_n = SHIFT;
`ifdef PISO_PARITY_EN
            par_n   = ^s.load_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            q_r    <= 1'b0;
            qv_r   <= 1'b0;
            done_r <= 1'b0;
`ifdef PISO_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            cnt    <= cnt_n;
            q_r    <= q_n;
            qv_r   <= qv_n;
            done_r <= done_n;
`ifdef PISO_PARITY_EN
            par    <= par_n;
`endif
        end
    end

    assign s.load_ready = ready;
    assign s.q          = q_r;
    assign s.q_valid    = qv_r;
    assign s.busy       = qv_r;
    assign s.done       = done_r;
endmodule
